// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_pkg
// Description : Shared types and helpers for the bit-serial subtractor.
//               Holds the FSM state encoding and the bit-counter width
//               function used by serial_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

    // FSM states: IDLE waits for start, RUN processes one bit per clock,
    // DONE flags the completed result for exactly one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the bit counter. The counter only has to reach W-1, so
    // $clog2(W) bits are enough; the guard keeps the width at least 1.
    function automatic int CW(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage : sub_pkg
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : One-bit full subtractor cell, purely combinational, written
//               gate by gate to match the lab adder cells.
//                 d    = x ^ y ^ bin
//                 bout = (~x & y) | (~(x ^ y) & bin)
// Ports       : x_i    - minuend bit
//               y_i    - subtrahend bit
//               bin_i  - borrow in from the previous (less significant) bit
//               d_o    - difference bit
//               bout_o - borrow out to the next (more significant) bit
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic x_i,
    input  logic y_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    logic w_x_xor_y;     // half-difference of the two operand bits
    logic w_not_x;
    logic w_borrow_gen;  // x=0, y=1: borrow generated by this bit alone
    logic w_xnor;
    logic w_borrow_prop; // x==y: incoming borrow passes straight through

    assign w_x_xor_y     = x_i ^ y_i;
    assign d_o           = w_x_xor_y ^ bin_i;

    assign w_not_x       = ~x_i;
    assign w_borrow_gen  = w_not_x & y_i;
    assign w_xnor        = ~w_x_xor_y;
    assign w_borrow_prop = w_xnor & bin_i;
    assign bout_o        = w_borrow_gen | w_borrow_prop;

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial two's-complement subtractor. Computes
//               diff = (a - b) mod 2^W one bit per clock, LSB first, through
//               a single full_subtractor cell and a registered borrow. A
//               start/done handshake sequences operations.
// Ports       : clk_i    - rising-edge clock
//               rst_ni   - asynchronous active-low reset
//               start_i  - request a subtraction (sampled only in IDLE)
//               a_i      - minuend, captured on the accepted start edge
//               b_i      - subtrahend, captured on the accepted start edge
//               busy_o   - high while bits are being processed
//               done_o   - one-cycle pulse; diff_o/bout_o valid from here on
//               diff_o   - a - b modulo 2^W, held until the next done
//               bout_o   - final unsigned borrow (1 when a < b)
// Parameters  : W        - operand/result width, legal range 2..16
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] diff_o,
    output logic         bout_o
);

    localparam int                  CNT_W    = CW(W);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [W-1:0]     sa_q, sa_d;      // minuend shift register
    logic [W-1:0]     sb_q, sb_d;      // subtrahend shift register
    logic [W-1:0]     sr_q, sr_d;      // result shift register
    logic             br_q, br_d;      // running borrow between bits
    logic [CNT_W-1:0] cnt_q, cnt_d;    // index of the bit being processed

    // Output registers kept apart from the shift registers so the outputs
    // never expose a partially shifted result.
    logic [W-1:0]     diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // ------------------------------------------------------------------------
    // Single full-subtractor cell working on the current LSBs
    // ------------------------------------------------------------------------
    logic w_d;
    logic w_bnext;

    full_subtractor u_fs (
        .x_i    (sa_q[0]),
        .y_i    (sb_q[0]),
        .bin_i  (br_q),
        .d_o    (w_d),
        .bout_o (w_bnext)
    );

    // Result register after this cycle's bit is shifted in at the MSB.
    logic [W-1:0] w_sr_shifted;
    assign w_sr_shifted = {w_d, sr_q[W-1:1]};

    // ------------------------------------------------------------------------
    // Sequential process
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic. busy/done are computed for the state
    // being entered so that they come straight out of flops.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    sa_d    = a_i;
                    sb_d    = b_i;
                    sr_d    = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end

            RUN: begin
                sa_d = {1'b0, sa_q[W-1:1]};
                sb_d = {1'b0, sb_q[W-1:1]};
                sr_d = w_sr_shifted;
                br_d = w_bnext;
                if (cnt_q == CNT_LAST) begin
                    // Last bit: publish the complete result, including the
                    // bit produced in this very cycle.
                    cnt_d   = '0;
                    diff_d  = w_sr_shifted;
                    bout_d  = w_bnext;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    busy_d  = 1'b1;
                end
            end

            DONE: begin
                // A start seen here is deliberately dropped; the requester
                // must still be asserting it in the following IDLE cycle.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign diff_o = diff_q;
    assign bout_o = bout_q;

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor. Runs a W=4 and a
//               W=2 instance; expected results come from plain arithmetic
//               ((a - b) mod 2^W, a < b) and from the documented cycle
//               timing of the start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W4 = 4;
    localparam int W2 = 2;

    logic       clk;
    logic       rst_n;
    logic       start4;
    logic       start2;
    logic [3:0] a;
    logic [3:0] b;

    logic       busy4, done4, bout4;
    logic [3:0] diff4;
    logic       busy2, done2, bout2;
    logic [1:0] diff2;

    int n_cmp;
    int n_fail;

    serial_subtractor #(.W(W4)) u_dut4 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start4),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (busy4),
        .done_o  (done4),
        .diff_o  (diff4),
        .bout_o  (bout4)
    );

    serial_subtractor #(.W(W2)) u_dut2 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start2),
        .a_i     (a[1:0]),
        .b_i     (b[1:0]),
        .busy_o  (busy2),
        .done_o  (done2),
        .diff_o  (diff2),
        .bout_o  (bout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: plain modular arithmetic.
    // ------------------------------------------------------------------------
    function automatic logic [3:0] ref_diff(input int w, input int av, input int bv);
        return 4'((av - bv) & ((1 << w) - 1));
    endfunction

    function automatic logic ref_bout(input int av, input int bv);
        return (av < bv);
    endfunction

    // ------------------------------------------------------------------------
    // One single-cycle start on the chosen instance, then observe a bounded
    // window of w+4 cycles. Sample index 1 is right after the accepting edge.
    // Operands are scrambled after acceptance to show they are not re-read.
    // ------------------------------------------------------------------------
    task automatic op(input int w, input logic [3:0] av, input logic [3:0] bv,
                      output logic [3:0] d, output logic bo,
                      output int done_at, output int nbusy,
                      output int ndone, output int noverlap);
        logic bsy, dn;
        done_at = 0; nbusy = 0; ndone = 0; noverlap = 0; d = '0; bo = 1'b0;
        a = av;
        b = bv;
        if (w == W2) start2 = 1'b1; else start4 = 1'b1;
        for (int i = 1; i <= w + 4; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                start2 = 1'b0;
                start4 = 1'b0;
                a = 4'($urandom);
                b = 4'($urandom);
            end
            if (w == W2) begin bsy = busy2; dn = done2; end
            else         begin bsy = busy4; dn = done4; end
            if (bsy) nbusy++;
            if (bsy && dn) noverlap++;
            if (dn) begin
                ndone++;
                if (done_at == 0) begin
                    done_at = i;
                    if (w == W2) begin d = {2'b00, diff2}; bo = bout2; end
                    else         begin d = diff4;          bo = bout4; end
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b1; start4 = 1'b0; start2 = 1'b0; a = '0; b = '0;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy4, done4, diff4, bout4} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_w4: got busy=%b done=%b diff=%0d bout=%b, want all 0",
                     busy4, done4, diff4, bout4);
        end
        n_cmp++;
        if ({busy2, done2, diff2, bout2} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_w2: got busy=%b done=%b diff=%0d bout=%b, want all 0",
                     busy2, done2, diff2, bout2);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy4, done4, diff4, bout4} !== 7'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b diff=%0d bout=%b, want all 0",
                     busy4, done4, diff4, bout4);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_directed();
        logic [3:0] va [4] = '{4'd9, 4'd5, 4'd0, 4'd15};
        logic [3:0] vb [4] = '{4'd5, 4'd9, 4'd1, 4'd15};
        logic [3:0] vd [4] = '{4'd4, 4'd12, 4'd15, 4'd0};
        logic       vo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] d;
        logic       bo;
        int done_at, nbusy, ndone, nov;
        for (int k = 0; k < 4; k++) begin
            op(W4, va[k], vb[k], d, bo, done_at, nbusy, ndone, nov);
            n_cmp++;
            if (d !== vd[k] || bo !== vo[k]) begin
                n_fail++;
                $display("FAIL directed_%0d_minus_%0d: got diff=%0d bout=%b, want diff=%0d bout=%b",
                         va[k], vb[k], d, bo, vd[k], vo[k]);
            end
            n_cmp++;
            if (done_at != W4 + 1 || nbusy != W4 || ndone != 1 || nov != 0) begin
                n_fail++;
                $display("FAIL directed_timing_%0d: got done_at=%0d busy_cycles=%0d dones=%0d overlap=%0d, want %0d %0d 1 0",
                         k, done_at, nbusy, ndone, nov, W4 + 1, W4);
            end
            repeat (3) @(posedge clk);
            #1;
            n_cmp++;
            if (diff4 !== vd[k] || bout4 !== vo[k]) begin
                n_fail++;
                $display("FAIL directed_hold_%0d: got diff=%0d bout=%b, want diff=%0d bout=%b",
                         k, diff4, bout4, vd[k], vo[k]);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // start re-asserted during RUN must be ignored; start during DONE is
    // ignored and the following IDLE cycle accepts it.
    // ------------------------------------------------------------------------
    task automatic test_ignore_start();
        int ndone1, ndone2, done2_at;
        logic [3:0] d1, d2;
        logic b1, b2;
        ndone1 = 0; ndone2 = 0; done2_at = 0; d1 = '0; d2 = '0; b1 = 1'b0; b2 = 1'b0;
        a = 4'd7; b = 4'd2; start4 = 1'b1;
        for (int i = 1; i <= 2 * W4 + 5; i++) begin
            @(posedge clk); #1;
            if (done4) begin
                if (i <= W4 + 1) begin ndone1++; d1 = diff4; b1 = bout4; end
                else begin ndone2++; done2_at = i; d2 = diff4; b2 = bout4; end
            end
            if (i == W4 + 2) begin
                n_cmp++;
                if (busy4 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_in_done_ignored: got busy=%b, want 0", busy4);
                end
            end
            if (i == W4 + 3) begin
                n_cmp++;
                if (busy4 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL start_in_idle_accepted: got busy=%b, want 1", busy4);
                end
            end
            case (i)
                1, 2:    begin start4 = 1'b1; a = 4'd1;  b = 4'd14; end
                W4 + 1:  begin start4 = 1'b1; a = 4'd3;  b = 4'd1;  end
                W4 + 3:  begin start4 = 1'b0; a = 4'd15; b = 4'd15; end
                default: begin if (i < W4 + 1) start4 = 1'b0; end
            endcase
        end
        start4 = 1'b0;
        n_cmp++;
        if (ndone1 != 1 || d1 !== 4'd5 || b1 !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start_first: got dones=%0d diff=%0d bout=%b, want 1 5 0",
                     ndone1, d1, b1);
        end
        n_cmp++;
        if (ndone2 != 1 || done2_at != 2 * W4 + 3 || d2 !== 4'd2 || b2 !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start_second: got dones=%0d done_at=%0d diff=%0d bout=%b, want 1 %0d 2 0",
                     ndone2, done2_at, d2, b2, 2 * W4 + 3);
        end
    endtask

    // ------------------------------------------------------------------------
    // start held high: accepts every W+2 edges; results follow the operands
    // present at each accepting edge.
    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        int qa[$];
        int qb[$];
        int ea, eb;
        logic exp_done;
        start4 = 1'b1;
        for (int j = 0; j < 4 * (W4 + 2); j++) begin
            a = 4'($urandom);
            b = 4'($urandom);
            if (j % (W4 + 2) == 0) begin
                qa.push_back(int'(a));
                qb.push_back(int'(b));
            end
            @(posedge clk); #1;
            exp_done = (j % (W4 + 2) == W4);
            n_cmp++;
            if (done4 !== exp_done) begin
                n_fail++;
                $display("FAIL b2b_done_edge_%0d: got done=%b, want %b", j, done4, exp_done);
            end
            if (exp_done && done4 && qa.size() > 0) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                n_cmp++;
                if (diff4 !== ref_diff(W4, ea, eb) || bout4 !== ref_bout(ea, eb)) begin
                    n_fail++;
                    $display("FAIL b2b_result_%0d_minus_%0d: got diff=%0d bout=%b, want diff=%0d bout=%b",
                             ea, eb, diff4, bout4, ref_diff(W4, ea, eb), ref_bout(ea, eb));
                end
            end
        end
        start4 = 1'b0;
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_run();
        logic [3:0] d;
        logic bo;
        int done_at, nbusy, ndone, nov, late;
        op(W4, 4'd1, 4'd0, d, bo, done_at, nbusy, ndone, nov);
        a = 4'd12; b = 4'd3; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (busy4 !== 1'b1 || diff4 !== 4'd1) begin
            n_fail++;
            $display("FAIL before_abort: got busy=%b diff=%0d, want busy=1 diff=1", busy4, diff4);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy4, done4, diff4, bout4} !== 7'd0) begin
            n_fail++;
            $display("FAIL async_abort: got busy=%b done=%b diff=%0d bout=%b, want all 0",
                     busy4, done4, diff4, bout4);
        end
        @(negedge clk) rst_n = 1'b1;
        late = 0;
        for (int i = 0; i < W4 + 4; i++) begin
            @(posedge clk); #1;
            if (done4 || busy4) late++;
        end
        n_cmp++;
        if (late != 0) begin
            n_fail++;
            $display("FAIL no_done_after_abort: got %0d active cycles, want 0", late);
        end
        op(W4, 4'd12, 4'd3, d, bo, done_at, nbusy, ndone, nov);
        n_cmp++;
        if (d !== 4'd9 || bo !== 1'b0 || done_at != W4 + 1 || ndone != 1) begin
            n_fail++;
            $display("FAIL fresh_after_abort: got diff=%0d bout=%b done_at=%0d dones=%0d, want 9 0 %0d 1",
                     d, bo, done_at, ndone, W4 + 1);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_sweep(input int w);
        logic [3:0] d;
        logic bo;
        int done_at, nbusy, ndone, nov;
        int lim;
        lim = 1 << w;
        for (int av = 0; av < lim; av++) begin
            for (int bv = 0; bv < lim; bv++) begin
                op(w, 4'(av), 4'(bv), d, bo, done_at, nbusy, ndone, nov);
                n_cmp++;
                if (d !== ref_diff(w, av, bv) || bo !== ref_bout(av, bv) ||
                    done_at != w + 1 || nbusy != w || ndone != 1 || nov != 0) begin
                    n_fail++;
                    $display("FAIL sweep_w%0d_%0d_minus_%0d: got diff=%0d bout=%b done_at=%0d busy=%0d dones=%0d ovl=%0d, want diff=%0d bout=%b done_at=%0d busy=%0d dones=1 ovl=0",
                             w, av, bv, d, bo, done_at, nbusy, ndone, nov,
                             ref_diff(w, av, bv), ref_bout(av, bv), w + 1, w);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep(W2);
        test_sweep(W4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_serial_subtractor
`default_nettype wire
